hanning_frame_buffer: RTL

- Receiving end of the windowing stage's sample stream: takes one windowed sample per valid pulse and assembles FRAME_LEN-sample frames.
- Uses ping-pong BRAM banks.
- Streams each complete frame to the FFT core over an AXI-Stream master with tlast on the final sample.
- Absorbs FFT backpressure; drops whole frames cleanly when both banks are occupied.

---
 rtl/hanning_frame_buffer.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hanning_frame_buffer.sv
// hanning_frame_buffer
//   Collects windowed samples into FRAME_LEN-sample frames using two ping-pong
//   BRAM banks and streams each complete frame to the FFT core over an
//   AXI-Stream master. Whole frames are dropped when no bank is free.
//
// Ports:
//   clk_in, rst_n_in      clock, asynchronous active-low reset
//   sample_in             signed windowed sample (DATA_WIDTH)
//   sample_valid_in       single-cycle strobe qualifying sample_in
//   m_axis_tdata          {imag = 0, real = sign-extended sample} (2*OUT_WIDTH)
//   m_axis_tvalid/tlast   beat valid / final beat of a frame
//   m_axis_tready         FFT ready
//   overflow_out          sticky: at least one frame dropped since reset
//   flush_in              only with HFB_FLUSH_EN: zero-fill and release the
//                         partially filled bank
//
// Build option: define HFB_FLUSH_EN to add flush_in and the zero-fill path.
module hanning_frame_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAME_LEN  = 4096
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [DATA_WIDTH-1:0]   sample_in,
  input  logic                    sample_valid_in,
  output logic [2*OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    overflow_out
`ifdef HFB_FLUSH_EN
  ,
  input  logic                    flush_in
`endif
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] ADDR_LAST = AW'(FRAME_LEN - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  localparam logic [1:0] BK_EMPTY    = 2'd0;
  localparam logic [1:0] BK_FILLING  = 2'd1;
  localparam logic [1:0] BK_FULL     = 2'd2;
  localparam logic [1:0] BK_DRAINING = 2'd3;

  localparam logic [1:0] RD_IDLE   = 2'd0;
  localparam logic [1:0] RD_PRIME  = 2'd1;
  localparam logic [1:0] RD_STREAM = 2'd2;

  // Both banks share one array; the bank index is the address MSB.
  logic [DATA_WIDTH-1:0] mem_q [0:2*FRAME_LEN-1];

  logic [1:0][1:0]       bank_st_q, bank_st_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic                  drop_q, drop_d;
  logic [AW-1:0]         drop_cnt_q, drop_cnt_d;
  logic                  ovf_q, ovf_d;
  logic [1:0]            rd_state_q, rd_state_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic                  rd_done_q, rd_done_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_vld_q, rd_last_q;
  logic [DATA_WIDTH-1:0] skid_data_q, out_data_q;
  logic                  skid_vld_q, skid_last_q, out_vld_q, out_last_q;

  logic                  we_s, re_s, re_bank_s, re_last_s, pop_s, room_s;
  logic                  fill_active_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [AW-1:0]         re_addr_s;
  logic [1:0]            wr_st_s, occ_s;
  logic signed [OUT_WIDTH-1:0] real_s;

`ifdef HFB_FLUSH_EN
  logic fill_q, fill_d;
  assign fill_active_s = fill_q;
`else
  assign fill_active_s = 1'b0;
`endif

  assign wr_st_s   = bank_st_q[wr_bank_q];
  assign pop_s     = out_vld_q & m_axis_tready;
  // Entries held or in flight (output reg, skid reg, BRAM read); a read is only
  // issued when its data is guaranteed a slot, so the skid never overflows.
  assign occ_s     = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_q};
  assign room_s    = (occ_s - {1'b0, pop_s}) < 2'd2;
  assign re_last_s = (re_addr_s == ADDR_LAST);

  // Next-state for the write side, bank states and the read FSM.
  always_comb begin
    bank_st_d  = bank_st_q;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    drop_d     = drop_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    we_s       = 1'b0;
    wdata_s    = sample_in;
`ifdef HFB_FLUSH_EN
    fill_d     = fill_q;
`endif
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_addr_d  = rd_addr_q;
    rd_done_d  = rd_done_q;
    re_s       = 1'b0;
    re_bank_s  = rd_bank_q;
    re_addr_s  = rd_addr_q;

    // Write side. Once a frame's first sample is refused, the rest of that
    // frame is refused too, even if a bank frees up part-way through, so a
    // frame is never split.
    if (fill_active_s) begin
      we_s    = 1'b1;
      wdata_s = {DATA_WIDTH{1'b0}};
      if (sample_valid_in) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else if (sample_valid_in) begin
      if (drop_q) begin
        ovf_d      = 1'b1;
        drop_cnt_d = drop_cnt_q + ADDR_ONE;
        drop_d     = (drop_cnt_q != ADDR_LAST);
      end else if (wr_st_s == BK_EMPTY || wr_st_s == BK_FILLING) begin
        we_s = 1'b1;
      end else begin
        ovf_d      = 1'b1;
        drop_d     = 1'b1;
        drop_cnt_d = ADDR_ONE;
      end
    end else begin
      we_s = 1'b0;
    end

`ifdef HFB_FLUSH_EN
    if (flush_in && !fill_q && wr_st_s == BK_FILLING) begin
      fill_d = 1'b1;
    end else begin
      fill_d = fill_q;
    end
`endif

    // A write that completes the frame also ends any zero-fill (including
    // a flush that arrives with the final real sample).
    if (we_s) begin
      if (wr_addr_q == ADDR_LAST) begin
        bank_st_d[wr_bank_q] = BK_FULL;
        wr_bank_d            = ~wr_bank_q;
        wr_addr_d            = {AW{1'b0}};
`ifdef HFB_FLUSH_EN
        fill_d               = 1'b0;
`endif
      end else begin
        bank_st_d[wr_bank_q] = BK_FILLING;
        wr_addr_d            = wr_addr_q + ADDR_ONE;
      end
    end else begin
      wr_addr_d = wr_addr_q;
    end

    // Read side only touches FULL/DRAINING banks, the write side only
    // EMPTY/FILLING ones, so both updates can land in the same cycle.
    case (rd_state_q)
      RD_IDLE: begin
        if (bank_st_q[rd_bank_q] == BK_FULL) begin
          bank_st_d[rd_bank_q] = BK_DRAINING;
          re_s       = 1'b1;
          re_addr_s  = {AW{1'b0}};
          rd_addr_d  = ADDR_ONE;
          rd_done_d  = 1'b0;
          rd_state_d = RD_PRIME;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_PRIME, RD_STREAM: begin
        if (!rd_done_q && room_s) begin
          re_s      = 1'b1;
          re_addr_s = rd_addr_q;
          rd_addr_d = rd_addr_q + ADDR_ONE;
          rd_done_d = (rd_addr_q == ADDR_LAST);
        end else begin
          rd_addr_d = rd_addr_q;
        end
        if (rd_state_q == RD_PRIME) begin
          rd_state_d = RD_STREAM;
        end else if (pop_s && out_last_q) begin
          // Frame handed off; claim the other bank at once if it is waiting.
          bank_st_d[rd_bank_q] = BK_EMPTY;
          rd_bank_d            = ~rd_bank_q;
          if (bank_st_q[~rd_bank_q] == BK_FULL) begin
            bank_st_d[~rd_bank_q] = BK_DRAINING;
            re_s       = 1'b1;
            re_bank_s  = ~rd_bank_q;
            re_addr_s  = {AW{1'b0}};
            rd_addr_d  = ADDR_ONE;
            rd_done_d  = 1'b0;
            rd_state_d = RD_PRIME;
          end else begin
            rd_state_d = RD_IDLE;
          end
        end else begin
          rd_state_d = RD_STREAM;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // Sample memory and its registered read port (no reset, maps to BRAM).
  always_ff @(posedge clk_in) begin
    if (we_s) begin
      mem_q[{wr_bank_q, wr_addr_q}] <= wdata_s;
    end
    if (re_s) begin
      rd_data_q <= mem_q[{re_bank_s, re_addr_s}];
    end
  end

  // Control state, skid buffer and AXI output register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bank_st_q   <= {BK_EMPTY, BK_EMPTY};
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= {AW{1'b0}};
      drop_q      <= 1'b0;
      drop_cnt_q  <= {AW{1'b0}};
      ovf_q       <= 1'b0;
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= {AW{1'b0}};
      rd_done_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      skid_data_q <= {DATA_WIDTH{1'b0}};
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      out_data_q  <= {DATA_WIDTH{1'b0}};
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef HFB_FLUSH_EN
      fill_q      <= 1'b0;
`endif
    end else begin
      bank_st_q  <= bank_st_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
      rd_done_q  <= rd_done_d;
      rd_vld_q   <= re_s;
      rd_last_q  <= re_last_s;
`ifdef HFB_FLUSH_EN
      fill_q     <= fill_d;
`endif
      // Output register takes the oldest entry (skid first, then BRAM data);
      // while stalled it holds and BRAM data parks in the skid.
      if (!out_vld_q || m_axis_tready) begin
        if (skid_vld_q) begin
          out_data_q  <= skid_data_q;
          out_last_q  <= skid_last_q;
          out_vld_q   <= 1'b1;
          skid_vld_q  <= rd_vld_q;
          skid_data_q <= rd_data_q;
          skid_last_q <= rd_last_q;
        end else if (rd_vld_q) begin
          out_data_q  <= rd_data_q;
          out_last_q  <= rd_last_q;
          out_vld_q   <= 1'b1;
          skid_vld_q  <= 1'b0;
        end else begin
          out_vld_q   <= 1'b0;
          out_last_q  <= 1'b0;
        end
      end else begin
        if (rd_vld_q) begin
          skid_data_q <= rd_data_q;
          skid_last_q <= rd_last_q;
          skid_vld_q  <= 1'b1;
        end else begin
          skid_vld_q  <= skid_vld_q;
        end
      end
    end
  end

  assign real_s        = OUT_WIDTH'($signed(out_data_q));
  assign m_axis_tdata  = {{OUT_WIDTH{1'b0}}, real_s};
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tlast  = out_last_q;
  assign overflow_out  = ovf_q;

endmodule
